instr_issue_unit: RTL and testbench



---
 rtl/instr_issue_unit_if.sv | 32 +++
 rtl/instr_issue_unit.sv | 192 +++++++++++++++++++
 tb/tb_instr_issue_unit.sv | 345 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_issue_unit_if.sv
// ---------------------------------------------------------------------------
// instr_issue_unit_if
// Instruction bus between the issue unit (master) and the processor (slave).
//   opcode      [2:0]  instruction opcode, 000 = no-op
//   in_addr1    [2:0]  first source register (IR[5:3])
//   in_addr2    [2:0]  second source register (IR[2:0])
//   dest_addr   [2:0]  destination register (IR[8:6])
//   branch_addr [5:0]  encoded branch target (IR[5:0])
//   issue_valid        one-cycle strobe per issued instruction
//   branch_flag        processor -> issue unit, 1 = branch taken
//   branch_out  [7:0]  processor -> issue unit, resolved target (low 6 bits used)
// ---------------------------------------------------------------------------
interface instr_issue_unit_if;
  logic [2:0] opcode;
  logic [2:0] in_addr1;
  logic [2:0] in_addr2;
  logic [2:0] dest_addr;
  logic [5:0] branch_addr;
  logic       issue_valid;
  logic       branch_flag;
  logic [7:0] branch_out;

  modport master (
    output opcode, in_addr1, in_addr2, dest_addr, branch_addr, issue_valid,
    input  branch_flag, branch_out
  );

  modport slave (
    input  opcode, in_addr1, in_addr2, dest_addr, branch_addr, issue_valid,
    output branch_flag, branch_out
  );
endinterface

// File: rtl/instr_issue_unit.sv
// ---------------------------------------------------------------------------
// instr_issue_unit
// Instruction fetch/issue sequencer. Holds a loadable program memory and a
// PC, fetches one word at a time, drives the decoded fields to the processor
// and redirects the PC from the processor's branch resolution.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   start, start_pc       begin execution at start_pc (IDLE/HALT only)
//   prog_we/addr/data     program-memory write port (IDLE/HALT only)
//   bus (master)          instruction bus to the processor, see the interface
//   pc                    current program counter
//   busy                  high in FETCH/ISSUE/WAIT_BR
//   halted                high in HALT
//   retire_count          saturating count of issued instructions, only
//                         present when IIU_RETIRE_CNT_EN is defined
//
// Optional feature macro: IIU_RETIRE_CNT_EN
// ---------------------------------------------------------------------------
module instr_issue_unit #(
  parameter int          IMEM_DEPTH = 64,
  parameter int          BR_WAIT    = 2,       // legal 1..7
  parameter logic [11:0] HALT_WORD  = 12'h1C0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [$clog2(IMEM_DEPTH)-1:0] start_pc,
  input  logic                          prog_we,
  input  logic [$clog2(IMEM_DEPTH)-1:0] prog_addr,
  input  logic [11:0]                   prog_data,
  instr_issue_unit_if.master            bus,
  output logic [$clog2(IMEM_DEPTH)-1:0] pc,
  output logic                          busy,
  output logic                          halted
`ifdef IIU_RETIRE_CNT_EN
  ,
  output logic [15:0]                   retire_count
`endif
);

  localparam int PC_W = $clog2(IMEM_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_WAIT_BR,
    S_HALT
  } state_e;

  state_e            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [11:0]       ir_q, ir_d;
  logic [11:0]       out_ir_q, out_ir_d;   // word currently presented on the bus
  logic              valid_q, valid_d;
  logic [2:0]        wcnt_q, wcnt_d;
  logic              busy_q, busy_d;
  logic              halted_q, halted_d;

  logic [11:0]       imem [IMEM_DEPTH];
  logic [11:0]       rd_word;
  logic              ctl_ok;
  logic              start_ok;
  logic              mem_we;
  logic              unused_br_hi;

  // Loading and starting are only accepted while the sequencer is parked.
  assign ctl_ok   = (state_q == S_IDLE) || (state_q == S_HALT);
  assign start_ok = start && ctl_ok;
  assign mem_we   = prog_we && ctl_ok;
  assign rd_word  = imem[pc_q];

  // Only the low PC_W bits of the processor's branch target are meaningful.
  assign unused_br_hi = ^bus.branch_out[7:PC_W];

  // NOTE: the program memory has no reset so it maps onto plain RAM; its
  // contents survive rst and must be loaded before use.
  always_ff @(posedge clk) begin
    if (mem_we) imem[prog_addr] <= prog_data;
  end

  always_comb begin
    // NOTE: every _d gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    out_ir_d = out_ir_q;
    valid_d  = 1'b0;
    wcnt_d   = wcnt_q;

    unique case (state_q)
      S_IDLE, S_HALT: begin
        if (start_ok) begin
          pc_d    = start_pc;
          state_d = S_FETCH;
        end
      end

      S_FETCH: begin
        // Outputs are registered, so the bus word is decided here together
        // with IR; a halt word is never presented.
        ir_d    = rd_word;
        state_d = S_ISSUE;
        if (rd_word != HALT_WORD) begin
          out_ir_d = rd_word;
          valid_d  = 1'b1;
        end
      end

      S_ISSUE: begin
        if (ir_q == HALT_WORD) begin
          state_d = S_HALT;
        end else if (ir_q[11:9] == 3'b111) begin
          wcnt_d  = 3'(BR_WAIT);
          state_d = S_WAIT_BR;
        end else begin
          pc_d     = pc_q + PC_W'(1);
          out_ir_d = '0;
          state_d  = S_FETCH;
        end
      end

      S_WAIT_BR: begin
        wcnt_d = wcnt_q - 3'd1;
        if (wcnt_q == 3'd1) begin
          pc_d     = bus.branch_flag ? bus.branch_out[PC_W-1:0] : pc_q + PC_W'(1);
          out_ir_d = '0;
          state_d  = S_FETCH;
        end
      end

      default: state_d = S_IDLE;
    endcase

    busy_d   = (state_d == S_FETCH) || (state_d == S_ISSUE) || (state_d == S_WAIT_BR);
    halted_d = (state_d == S_HALT);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples values from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      ir_q     <= '0;
      out_ir_q <= '0;
      valid_q  <= 1'b0;
      wcnt_q   <= '0;
      busy_q   <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      out_ir_q <= out_ir_d;
      valid_q  <= valid_d;
      wcnt_q   <= wcnt_d;
      busy_q   <= busy_d;
      halted_q <= halted_d;
    end
  end

  assign bus.opcode      = out_ir_q[11:9];
  assign bus.dest_addr   = out_ir_q[8:6];
  assign bus.in_addr1    = out_ir_q[5:3];
  assign bus.in_addr2    = out_ir_q[2:0];
  assign bus.branch_addr = out_ir_q[5:0];
  assign bus.issue_valid = valid_q;
  assign pc              = pc_q;
  assign busy            = busy_q;
  assign halted          = halted_q;

`ifdef IIU_RETIRE_CNT_EN
  logic [15:0] retire_q, retire_d;

  always_comb begin
    retire_d = retire_q;
    if (start_ok)                            retire_d = '0;
    else if (valid_q && retire_q != 16'hFFFF) retire_d = retire_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) retire_q <= '0;
    else     retire_q <= retire_d;
  end

  assign retire_count = retire_q;
`endif

endmodule

// File: tb/tb_instr_issue_unit.sv
// ---------------------------------------------------------------------------
// tb_instr_issue_unit
// Self-checking bench for instr_issue_unit. A program-level model walks the
// loaded program (issue timing, branch decisions, halt) and predicts every
// cycle's bus, pc, busy and halted values.
// ---------------------------------------------------------------------------
module tb_instr_issue_unit;
  localparam logic [11:0] HALT_WORD = 12'h1C0;
  localparam int          BR_WAIT   = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [5:0]  start_pc;
  logic        prog_we;
  logic [5:0]  prog_addr;
  logic [11:0] prog_data;
  logic [5:0]  pc;
  logic        busy;
  logic        halted;
`ifdef IIU_RETIRE_CNT_EN
  logic [15:0] retire_count;
`endif

  instr_issue_unit_if bus ();

  instr_issue_unit #(
    .IMEM_DEPTH(64),
    .BR_WAIT   (BR_WAIT),
    .HALT_WORD (HALT_WORD)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .start_pc (start_pc),
    .prog_we  (prog_we),
    .prog_addr(prog_addr),
    .prog_data(prog_data),
    .bus      (bus),
    .pc       (pc),
    .busy     (busy),
    .halted   (halted)
`ifdef IIU_RETIRE_CNT_EN
    ,
    .retire_count(retire_count)
`endif
  );

  always #5 clk = ~clk;

  int          checks   = 0;
  int          failures = 0;
  logic [11:0] ref_mem [64];
  int          bf_mode  = 0;     // 0 random, 1 force taken, 2 force not-taken
  logic [7:0]  bf_target = 8'h00;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [5:0] a, input logic [11:0] d);
    prog_we   = 1'b1;
    prog_addr = a;
    prog_data = d;
    step();
    prog_we   = 1'b0;
    ref_mem[a] = d;
  endtask

  function automatic logic [11:0] rand_plain();
    logic [11:0] w;
    w = {3'($urandom_range(0, 6)), 9'($urandom)};
    if (w == HALT_WORD) w = 12'h000;
    return w;
  endfunction

  // Pulses start, then predicts and compares every cycle until the model
  // reaches HALT or the cycle budget runs out.
  task automatic run_program(input logic [5:0] spc, input int budget, input bit junk,
                             output bit done, output int halt_cyc);
    logic [5:0]  model_pc, pending_pc;
    logic [11:0] cur_word, exp_word, got_word;
    int          cur_e, next_fetch, win_end;
    bit          is_halt, is_br, exp_valid, exp_halted, samp;
    logic        bf;
    logic [7:0]  bo;
    start = 1'b1;
    start_pc = spc;
    step();
    start = 1'b0;
    model_pc = spc;  pending_pc = spc;
    next_fetch = 0;  cur_e = 1;  cur_word = 12'h0;
    done = 1'b0;     halt_cyc = -1;
    for (int cyc = 0; cyc < budget; cyc++) begin
      if (cyc == next_fetch) begin
        model_pc = pending_pc;
        cur_e    = cyc + 1;
        cur_word = ref_mem[model_pc];
      end
      is_halt    = (cur_word == HALT_WORD);
      is_br      = !is_halt && (cur_word[11:9] == 3'b111);
      win_end    = is_br ? cur_e + BR_WAIT : cur_e;
      exp_valid  = (cyc == cur_e) && !is_halt;
      exp_word   = (!is_halt && cyc >= cur_e && cyc <= win_end) ? cur_word : 12'h0;
      exp_halted = is_halt && (cyc > cur_e);
      got_word   = {bus.opcode, bus.dest_addr, bus.in_addr1, bus.in_addr2};

      checks++;
      if (bus.issue_valid !== exp_valid) begin
        failures++;
        $display("FAIL issue_valid cyc=%0d got=%b exp=%b", cyc, bus.issue_valid, exp_valid);
      end
      checks++;
      if (got_word !== exp_word || bus.branch_addr !== exp_word[5:0]) begin
        failures++;
        $display("FAIL fields cyc=%0d got=%h br=%h exp=%h", cyc, got_word, bus.branch_addr, exp_word);
      end
      checks++;
      if (pc !== model_pc) begin
        failures++;
        $display("FAIL pc cyc=%0d got=%0d exp=%0d", cyc, pc, model_pc);
      end
      checks++;
      if (busy !== !exp_halted) begin
        failures++;
        $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, !exp_halted);
      end
      checks++;
      if (halted !== exp_halted) begin
        failures++;
        $display("FAIL halted cyc=%0d got=%b exp=%b", cyc, halted, exp_halted);
      end
      if (exp_halted) begin
        done = 1'b1;
        halt_cyc = cyc;
        break;
      end

      if (junk) begin
        start     = 1'($urandom_range(0, 1));
        start_pc  = 6'($urandom);
        prog_we   = 1'($urandom_range(0, 1));
        prog_addr = 6'($urandom);
        prog_data = 12'($urandom);
      end
      samp = is_br && (cyc == win_end);
      bf = 1'($urandom_range(0, 1));
      bo = 8'($urandom);
      if (bf_mode == 1 && samp) begin bf = 1'b1; bo = bf_target; end
      if (bf_mode == 2) bf = !samp;
      bus.branch_flag = bf;
      bus.branch_out  = bo;
      if (samp) pending_pc = bf ? bo[5:0] : model_pc + 6'd1;
      if (!is_halt && !is_br && cyc == cur_e) pending_pc = model_pc + 6'd1;
      if (!is_halt && cyc == win_end) next_fetch = cyc + 1;
      step();
    end
    start   = 1'b0;
    prog_we = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks++;
    if ({bus.opcode, bus.dest_addr, bus.in_addr1, bus.in_addr2, bus.branch_addr,
         bus.issue_valid, pc, busy, halted} !== '0) begin
      failures++;
      $display("FAIL reset_state got op=%b pc=%0d busy=%b halted=%b valid=%b",
               bus.opcode, pc, busy, halted, bus.issue_valid);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_basic();
    bit done; int hc;
    load(6'd0, 12'h24B);
    load(6'd1, HALT_WORD);
    run_program(6'd0, 50, 1'b0, done, hc);
    checks++;
    if (!done || hc != 4 || pc !== 6'd1) begin
      failures++;
      $display("FAIL basic_halt done=%b cycles=%0d pc=%0d exp cycles=4 pc=1", done, hc, pc);
    end
  endtask

  task automatic test_branch(input bit taken);
    bit done; int hc;
    logic [5:0] exp_pc;
    exp_pc = taken ? 6'd20 : 6'd6;
    load(6'd5, 12'hE0A);
    load(exp_pc, HALT_WORD);
    bf_mode   = taken ? 1 : 2;
    bf_target = 8'h14;
    run_program(6'd5, 50, 1'b0, done, hc);
    bf_mode = 0;
    checks++;
    if (!done || hc != 2 + BR_WAIT + 2 || pc !== exp_pc) begin
      failures++;
      $display("FAIL branch_%0s done=%b cycles=%0d pc=%0d exp pc=%0d",
               taken ? "taken" : "not_taken", done, hc, pc, exp_pc);
    end
  endtask

  task automatic test_wrap();
    bit done; int hc;
    load(6'd63, 12'h24B);
    load(6'd0, HALT_WORD);
    run_program(6'd63, 50, 1'b0, done, hc);
    checks++;
    if (!done || hc != 4 || pc !== 6'd0) begin
      failures++;
      $display("FAIL wrap done=%b cycles=%0d pc=%0d exp pc=0", done, hc, pc);
    end
  endtask

  // Straight-line program over all 64 words; junk start/prog_we while busy,
  // then a clean rerun re-reads every word against the model memory.
  task automatic test_busy_ignore();
    bit done; int hc;
    logic [5:0] h;
    h = 6'($urandom);
    for (int i = 0; i < 64; i++) load(6'(i), (6'(i) == h) ? HALT_WORD : rand_plain());
    for (int pass = 0; pass < 2; pass++) begin
      run_program(h + 6'd1, 300, pass == 0, done, hc);
      checks++;
      if (!done || hc != 63 * 2 + 2) begin
        failures++;
        $display("FAIL busy_ignore pass=%0d done=%b cycles=%0d exp=128", pass, done, hc);
      end
    end
  endtask

  task automatic test_reset_in_wait();
    load(6'd5, 12'hE0A);
    start = 1'b1; start_pc = 6'd5;
    step();
    start = 1'b0;
    step();   // ISSUE
    step();   // first WAIT_BR cycle
    checks++;
    if (bus.branch_addr !== 6'h0A || bus.issue_valid !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL wait_hold br=%h valid=%b busy=%b exp br=0a valid=0 busy=1",
               bus.branch_addr, bus.issue_valid, busy);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if ({bus.opcode, bus.dest_addr, bus.in_addr1, bus.in_addr2, bus.branch_addr,
         bus.issue_valid, pc, busy, halted} !== '0) begin
      failures++;
      $display("FAIL reset_in_wait op=%b br=%h pc=%0d busy=%b halted=%b",
               bus.opcode, bus.branch_addr, pc, busy, halted);
    end
    step();
    checks++;
    if (busy !== 1'b0 || halted !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_reset busy=%b halted=%b exp 0 0", busy, halted);
    end
  endtask

  task automatic test_random();
    bit done; int hc;
    int r;
    for (int i = 0; i < 64; i++) begin
      r = $urandom_range(0, 99);
      if (r < 8)       load(6'(i), HALT_WORD);
      else if (r < 22) load(6'(i), {3'b111, 9'($urandom)});
      else             load(6'(i), rand_plain());
    end
    for (int n = 0; n < 8; n++) begin
      run_program(6'($urandom), 300, 1'b0, done, hc);
      if (!done) begin
        rst = 1'b1;
        step();
        rst = 1'b0;
      end
    end
  endtask

`ifdef IIU_RETIRE_CNT_EN
  task automatic test_retire();
    bit done; int hc;
    bit seen;
    load(6'd10, 12'h24B);
    load(6'd11, 12'h09A);
    load(6'd12, 12'h4C1);
    load(6'd13, HALT_WORD);
    run_program(6'd10, 50, 1'b0, done, hc);
    checks++;
    if (!done || retire_count !== 16'd3) begin
      failures++;
      $display("FAIL retire_count done=%b got=%0d exp=3", done, retire_count);
    end
    start = 1'b1; start_pc = 6'd13;
    step();
    start = 1'b0;
    checks++;
    if (retire_count !== 16'd0) begin
      failures++;
      $display("FAIL retire_clear got=%0d exp=0", retire_count);
    end
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step();
      seen = halted;
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL retire_restart_halt got=0 exp=1");
    end
  endtask
`endif

  initial begin
    rst = 1'b1;
    start = 1'b0;
    start_pc = '0;
    prog_we = 1'b0;
    prog_addr = '0;
    prog_data = '0;
    bus.branch_flag = 1'b0;
    bus.branch_out = '0;
    test_reset();
    test_basic();
    test_branch(1'b1);
    test_branch(1'b0);
    test_wrap();
    test_busy_ignore();
    test_reset_in_wait();
    test_random();
`ifdef IIU_RETIRE_CNT_EN
    test_retire();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
